shared_mem_arbiter: RTL and testbench

//  Shared-memory controller directly downstream of the N GPU cores' memory stage.

---
 rtl/gpu_pkg.sv | 20 ++
 rtl/sm_ram.sv | 28 ++
 rtl/shared_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU shared-memory arbiter: geometry, FSM states and op codes.
package gpu_pkg;

    localparam int N_CORES = 16;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT  = 2'd1,
        S_ACK  = 2'd2,
        S_POST = 2'd3
    } state_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_t;

endpackage

// File: rtl/sm_ram.sv
// Single-port shared RAM with a one-cycle synchronous read; contents survive reset.
module sm_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one shared RAM,
// one 4-cycle transaction (IDLE -> GNT -> ACK -> POST) at a time.
module shared_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int N_CORES = gpu_pkg::N_CORES,
    parameter int ADDR_W  = gpu_pkg::ADDR_W,
    parameter int DATA_W  = gpu_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          mem_req_ld,
    input  logic [N_CORES-1:0]          mem_req_st,
    input  logic [N_CORES*ADDR_W-1:0]   addr_flat,
    input  logic [N_CORES*DATA_W-1:0]   st_data_flat,
    output logic [N_CORES-1:0]          val_data,
    output logic [DATA_W-1:0]           mem_dat,
    output logic                        busy
);

    localparam int ID_W = $clog2(N_CORES);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    op_t                 op_q, op_d;
    logic [N_CORES-1:0]  val_data_q, val_data_d;
    logic [DATA_W-1:0]   mem_dat_q, mem_dat_d;

    logic [N_CORES-1:0]  req;
    logic [ID_W-1:0]     pick;
    logic                ram_we;
    logic                ram_re;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CORES-1:0] r,
                                                input logic [ID_W-1:0]    ptr);
        logic [2*N_CORES-1:0] dbl;
        logic [N_CORES-1:0]   rot;
        logic [ID_W-1:0]      k;
        logic [ID_W:0]        sum;
        logic                 found;
        dbl   = {r, r} >> ptr;
        rot   = dbl[N_CORES-1:0];
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!found && rot[i]) begin
                k     = ID_W'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, k};
        if (sum >= (ID_W+1)'(N_CORES)) begin
            sum = sum - (ID_W+1)'(N_CORES);
        end
        return sum[ID_W-1:0];
    endfunction

    assign req  = mem_req_ld | mem_req_st;
    assign pick = rr_pick(req, rr_ptr_q);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        addr_d     = addr_q;
        op_d       = op_q;
        val_data_d = '0;
        mem_dat_d  = mem_dat_q;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    gnt_id_d = pick;
                    addr_d   = addr_flat[int'(pick)*ADDR_W +: ADDR_W];
                    op_d     = mem_req_ld[pick] ? OP_LD : OP_ST;
                    state_d  = S_GNT;
                end
            end
            S_GNT: begin
                ram_re  = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                val_data_d[gnt_id_q] = 1'b1;
                if (op_q == OP_LD) begin
                    mem_dat_d = ram_rdata;
                end
                state_d = S_POST;
            end
            S_POST: begin
                // Gated by reset so an abort in POST never commits the store.
                ram_we   = (op_q == OP_ST) && !reset;
                rr_ptr_d = (gnt_id_q == ID_W'(N_CORES-1)) ? '0 : gnt_id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            val_data_q <= '0;
            mem_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            val_data_q <= val_data_d;
            mem_dat_q  <= mem_dat_d;
        end
        gnt_id_q <= gnt_id_d;
        addr_q   <= addr_d;
        op_q     <= op_d;
    end

    assign ram_wdata = st_data_flat[int'(gnt_id_q)*DATA_W +: DATA_W];

    sm_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign val_data = val_data_q;
    assign mem_dat  = mem_dat_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomised bench for shared_mem_arbiter checked against a transaction-level model.
module tb_shared_mem_arbiter;

    localparam int NC = 16;
    localparam int AW = 12;
    localparam int DW = 8;

    logic               clk;
    logic               reset;
    logic [NC-1:0]      mem_req_ld;
    logic [NC-1:0]      mem_req_st;
    logic [NC*AW-1:0]   addr_flat;
    logic [NC*DW-1:0]   st_data_flat;
    logic [NC-1:0]      val_data;
    logic [DW-1:0]      mem_dat;
    logic               busy;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    // Reference model: memory image, round-robin pointer, last load data.
    logic [DW-1:0] mem_m [2**AW];
    int            ptr_m;
    logic [DW-1:0] md_m;

    shared_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_ld   (mem_req_ld),
        .mem_req_st   (mem_req_st),
        .addr_flat    (addr_flat),
        .st_data_flat (st_data_flat),
        .val_data     (val_data),
        .mem_dat      (mem_dat),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick();
        int idx;
        for (int i = 0; i < NC; i++) begin
            idx = (ptr_m + i) % NC;
            if (mem_req_ld[idx] || mem_req_st[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int core, input bit ld, input bit st,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_req_ld[core]            = ld;
        mem_req_st[core]            = st;
        addr_flat[core*AW +: AW]    = a;
        st_data_flat[core*DW +: DW] = d;
    endtask

    task automatic model_reset();
        ptr_m = 0;
        md_m  = '0;
    endtask

    // Serve every pending request; called from an idle cycle at a negedge.
    task automatic service(input string tag);
        int            gap;
        int            first;
        int            g;
        bit            is_ld;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        gap   = 0;
        first = 1;
        while ((mem_req_ld | mem_req_st) != '0) begin
            @(negedge clk);
            gap++;
            if (val_data != '0) begin
                g     = model_pick();
                is_ld = mem_req_ld[g];
                a     = addr_flat[g*AW +: AW];
                exp_d = is_ld ? mem_m[a] : md_m;
                cmp_cnt++;
                if (val_data !== (NC'(1) << g)) begin
                    bad_cnt++;
                    $display("FAIL %s grant: val_data=%h expected %h", tag, val_data, NC'(1) << g);
                end
                cmp_cnt++;
                if (gap != (first ? 3 : 4)) begin
                    bad_cnt++;
                    $display("FAIL %s latency core %0d: %0d cycles expected %0d", tag, g, gap, first ? 3 : 4);
                end
                cmp_cnt++;
                if (mem_dat !== exp_d) begin
                    bad_cnt++;
                    $display("FAIL %s mem_dat core %0d ld=%0d addr %h: %h expected %h", tag, g, is_ld, a, mem_dat, exp_d);
                end
                cmp_cnt++;
                if (busy !== 1'b1) begin
                    bad_cnt++;
                    $display("FAIL %s busy at ack: %b expected 1", tag, busy);
                end
                if (is_ld) begin
                    md_m          = mem_m[a];
                    mem_req_ld[g] = 1'b0;
                end else begin
                    mem_m[a]      = st_data_flat[g*DW +: DW];
                    mem_req_st[g] = 1'b0;
                end
                ptr_m = (g + 1) % NC;
                gap   = 0;
                first = 0;
            end else if (gap > 6) begin
                cmp_cnt++;
                bad_cnt++;
                $display("FAIL %s timeout: no ack within %0d cycles, val_data=%h", tag, gap, val_data);
                mem_req_ld = '0;
                mem_req_st = '0;
                repeat (4) @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (val_data !== '0 || busy !== 1'b0) begin
            bad_cnt++;
            $display("FAIL %s idle after: val_data=%h busy=%b expected 0/0", tag, val_data, busy);
        end
    endtask

    task automatic do_reset(input string tag);
        reset      = 1'b1;
        mem_req_ld = '0;
        mem_req_st = '0;
        repeat (2) begin
            @(negedge clk);
            cmp_cnt++;
            if (val_data !== '0 || mem_dat !== '0 || busy !== 1'b0) begin
                bad_cnt++;
                $display("FAIL %s reset outputs: val_data=%h mem_dat=%h busy=%b expected 0/0/0", tag, val_data, mem_dat, busy);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 1'b1, 12'h200, 8'($urandom));
        set_req(5, 1'b0, 1'b1, 12'h201, 8'($urandom));
        set_req(9, 1'b0, 1'b1, 12'h202, 8'($urandom));
        repeat (2) begin
            @(negedge clk);
            cmp_cnt++;
            if (val_data !== '0 || mem_dat !== '0 || busy !== 1'b0) begin
                bad_cnt++;
                $display("FAIL reset outputs: val_data=%h mem_dat=%h busy=%b expected 0/0/0", val_data, mem_dat, busy);
            end
        end
        reset = 1'b0;
        model_reset();
        service("reset_first_grant");
    endtask

    task automatic test_store_load();
        set_req(3, 1'b0, 1'b1, 12'h123, 8'hA5);
        service("st_core3");
        set_req(3, 1'b1, 1'b0, 12'h123, 8'h00);
        service("ld_core3");
        cmp_cnt++;
        if (md_m !== 8'hA5 || mem_dat !== 8'hA5) begin
            bad_cnt++;
            $display("FAIL store_load readback: mem_dat=%h expected a5", mem_dat);
        end
    endtask

    task automatic test_all_loads();
        do_reset("pre_all");
        for (int k = 0; k < NC; k++) set_req(k, 1'b0, 1'b1, AW'(12'h300 + k), 8'($urandom));
        service("all_stores");
        for (int k = 0; k < NC; k++) set_req(k, 1'b1, 1'b0, AW'(12'h300 + k), 8'h00);
        service("all_loads");
    endtask

    task automatic test_wrap();
        set_req(15, 1'b1, 1'b0, 12'h30F, 8'h00);
        service("wrap_core15");
        set_req(2, 1'b1, 1'b0, 12'h302, 8'h00);
        set_req(15, 1'b1, 1'b0, 12'h30F, 8'h00);
        service("wrap_2_then_15");
    endtask

    task automatic test_ld_st_same();
        set_req(5, 1'b1, 1'b1, 12'h305, 8'($urandom));
        service("ldst_core5");
        set_req(5, 1'b1, 1'b0, 12'h305, 8'h00);
        service("ldst_readback");
    endtask

    task automatic test_reset_in_post();
        int waited;
        set_req(1, 1'b0, 1'b1, 12'h010, 8'h00);
        service("post_prestore");
        set_req(1, 1'b0, 1'b1, 12'h010, 8'h5A);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (val_data == '0 && waited < 8);
        cmp_cnt++;
        if (val_data !== NC'(1) << 1) begin
            bad_cnt++;
            $display("FAIL reset_in_post store ack: val_data=%h expected 0002", val_data);
        end
        do_reset("post_abort");
        set_req(1, 1'b1, 1'b0, 12'h010, 8'h00);
        service("post_reload");
        cmp_cnt++;
        if (mem_dat !== 8'h00) begin
            bad_cnt++;
            $display("FAIL reset_in_post reload: mem_dat=%h expected 00", mem_dat);
        end
    endtask

    task automatic test_random();
        int r;
        for (int round = 0; round < 20; round++) begin
            for (int k = 0; k < NC; k++) begin
                r = $urandom_range(0, 4);
                set_req(k, r == 1 || r == 3, r == 2 || r == 3,
                        AW'(12'h300 + $urandom_range(0, 7)), 8'($urandom));
            end
            service("random");
        end
    endtask

    initial begin
        reset        = 1'b1;
        mem_req_ld   = '0;
        mem_req_st   = '0;
        addr_flat    = '0;
        st_data_flat = '0;
        model_reset();
        test_reset();
        test_store_load();
        test_all_loads();
        test_wrap();
        test_ld_st_same();
        test_reset_in_post();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: bench did not complete");
        $fatal(1);
    end

endmodule
